// File: rtl/burst_mem_model.sv
// burst_mem_model
//   Main-memory model for cache testbenches. It holds a byte-addressed array that
//   starts at BASE_ADDR and has a fixed access latency. It serves single-word or
//   wrapping-burst (critical word first) reads and writes over valid/ready channels.
// Ports
//   clk, reset_n                        rising-edge clock, synchronous active-low reset
//   req_valid_i/req_ready_o             request handshake (ready only while idle)
//   req_we_i, req_burst_i, req_addr_i   write flag, burst flag, first-beat byte address
//   wdata_valid_i/wdata_ready_o         write-beat handshake (ready only while taking beats)
//   wdata_i, wdata_be_i                 write beat data and little-endian byte enables
//   rsp_valid_o/rsp_ready_i             response-beat handshake
//   rsp_data_o, rsp_last_o, rsp_err_o   read data (0 on ack/error), final beat, error
module burst_mem_model #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int unsigned LATENCY     = 4,
   parameter int unsigned BURST_LEN   = 4,
   parameter string       INIT_FILE   = ""
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic                req_burst_i,
   input  logic [31:0]         req_addr_i,
   input  logic                wdata_valid_i,
   output logic                wdata_ready_o,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wdata_be_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_data_o,
   output logic                rsp_last_o,
   output logic                rsp_err_o
);

   localparam int unsigned WB     = DATA_W / 8;
   localparam int unsigned LB     = $clog2(WB);
   localparam int unsigned BLK_B  = WB * BURST_LEN;
   localparam int unsigned WORDS  = DEPTH_BYTES / WB;
   localparam int unsigned AW     = $clog2(WORDS);
   localparam int unsigned BW     = $clog2(BURST_LEN);
   localparam int unsigned LW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned LAT_M2 = (LATENCY > 1) ? LATENCY - 2 : 0;

   typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WAIT, S_RESP} state_t;

   logic [DATA_W-1:0] mem [WORDS];

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = '0;
   end

   state_t            state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic              we_q, we_d, burst_q, burst_d, err_q, err_d;
   logic [AW-1:0]     off_w_q, off_w_d;
   logic              rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   // Request decode. The offset wraps in 32 bits, so addresses below BASE_ADDR
   // land far out of range and report an error.
   logic [31:0] off, blk_b;
   logic        req_err;
   assign off     = req_addr_i - BASE_ADDR;
   assign blk_b   = off & ~32'(BLK_B - 1);
   assign req_err = (off >= 32'(DEPTH_BYTES)) || (off[LB-1:0] != '0) ||
                    (req_burst_i && ({1'b0, blk_b} + 33'(BLK_B) > 33'(DEPTH_BYTES)));

   // Word index of the current beat. The burst wraps inside its aligned block, so a
   // single transfer (beat 0) is simply the request word.
   logic [AW-1:0] beat_word;
   logic          last_beat;
   assign beat_word = (off_w_q & ~AW'(BURST_LEN - 1)) |
                      ((off_w_q + AW'(beat_q)) & AW'(BURST_LEN - 1));
   assign last_beat = (beat_q == (burst_q ? BW'(BURST_LEN - 1) : '0));

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      lat_d       = lat_q;
      we_d        = we_q;
      burst_d     = burst_q;
      err_d       = err_q;
      off_w_d     = off_w_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_last_d  = rsp_last_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               burst_d = req_burst_i;
               err_d   = req_err;
               off_w_d = off[LB +: AW];
               beat_d  = '0;
               lat_d   = '0;
               if (req_we_i)          state_d = S_WDATA;
               else if (LATENCY == 1) state_d = S_RESP;
               else                   state_d = S_WAIT;
            end
         end
         S_WDATA: begin
            if (wdata_valid_i) begin
               if (last_beat) begin
                  beat_d  = '0;
                  lat_d   = '0;
                  state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (lat_q == LW'(LAT_M2)) state_d = S_RESP;
            else                      lat_d   = lat_q + 1'b1;
         end
         S_RESP: begin
            if (rsp_valid_q && rsp_ready_i && rsp_last_q) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_data_d  = '0;
               rsp_last_d  = 1'b0;
               rsp_err_d   = 1'b0;
            end else if (!rsp_valid_q || rsp_ready_i) begin
               // First beat one cycle after entry, then one beat per accepted beat.
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               rsp_data_d  = (err_q || we_q) ? '0 : mem[beat_word];
               rsp_last_d  = we_q || last_beat;
               beat_d      = beat_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         lat_q       <= '0;
         we_q        <= 1'b0;
         burst_q     <= 1'b0;
         err_q       <= 1'b0;
         off_w_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         lat_q       <= lat_d;
         we_q        <= we_d;
         burst_q     <= burst_d;
         err_q       <= err_d;
         off_w_q     <= off_w_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_last_q  <= rsp_last_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // The array has no reset. A beat that arrives on a reset edge is dropped, but
   // beats written before that edge stay in the array.
   always @(posedge clk) begin
      if (reset_n && (state_q == S_WDATA) && wdata_valid_i && !err_q) begin
         for (int b = 0; b < WB; b++) begin
            if (wdata_be_i[b]) mem[beat_word][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign req_ready_o   = (state_q == S_IDLE);
   assign wdata_ready_o = (state_q == S_WDATA);
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_data_o    = rsp_data_q;
   assign rsp_last_o    = rsp_last_q;
   assign rsp_err_o     = rsp_err_q;

endmodule
